alu_issue_ctrl: RTL

- Initiator side of the 16-bit ALU datapath. The ALU is a combinational responder taking op_code, rs1_in, rs2_in, cin and bin, and returning result.
- This block accepts 16-bit instruction words over a valid/ready handshake, reads operands from an internal register file, and drives the ALU operand/opcode ports.
- It captures the ALU result and writes it back to the destination register, then pulses done.
- It sits between the instruction source and the ALU top and owns all sequencing.

---
 rtl/alu_issue_ctrl.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: accepts 16-bit instruction words, drives a combinational ALU and writes results back.
// Optional build macro ALU_ISSUE_PERF_EN adds the perf_retired / perf_illegal counters.
module alu_issue_ctrl #(
    parameter int NREGS      = 8,
    parameter int DIV_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_instr,
    output logic [3:0]  op_code,
    output logic [15:0] rs1_in,
    output logic [15:0] rs2_in,
    output logic        cin,
    output logic        bin,
    input  logic [15:0] alu_result,
    output logic        done,
    output logic        err,
    input  logic [2:0]  dbg_addr,
    output logic [15:0] dbg_data
`ifdef ALU_ISSUE_PERF_EN
    ,
    output logic [15:0] perf_retired,
    output logic [15:0] perf_illegal
`endif
);

    localparam int              CNT_W     = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);
    localparam logic [3:0]      NREGS_LIM = 4'(NREGS);

    localparam logic [3:0] OP_DIV = 4'h3;
    localparam logic [3:0] OP_LDI = 4'h8;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DECODE,
        S_EXEC,
        S_WB
    } state_t;

    state_t            state;
    state_t            next_state;
    logic [15:0]       instr_q;
    logic [15:0]       result_q;
    logic [CNT_W-1:0]  div_cnt;
    logic              err_q;
    logic [15:0]       regs [NREGS];

    logic        accept;
    logic        load_alu;
    logic        load_ldi;
    logic        capture;
    logic        div_dec;
    logic        set_err;
    logic        wr_en;

    logic [3:0]  dec_op;
    logic [2:0]  dec_rd;
    logic [2:0]  dec_ra;
    logic [2:0]  dec_rb;
    logic [8:0]  dec_imm;
    logic        dec_is_alu;
    logic        dec_is_ldi;
    logic [15:0] read_a;
    logic [15:0] read_b;
    logic        dst_ok;

    assign dec_op     = instr_q[15:12];
    assign dec_rd     = instr_q[11:9];
    assign dec_ra     = instr_q[8:6];
    assign dec_rb     = instr_q[5:3];
    assign dec_imm    = instr_q[8:0];
    assign dec_is_alu = (dec_op[3:2] == 2'b00);
    assign dec_is_ldi = (dec_op == OP_LDI);

    // Indices beyond NREGS read as zero and are never written.
    assign read_a   = ({1'b0, dec_ra} < NREGS_LIM) ? regs[dec_ra] : 16'h0000;
    assign read_b   = ({1'b0, dec_rb} < NREGS_LIM) ? regs[dec_rb] : 16'h0000;
    assign dst_ok   = ({1'b0, dec_rd} < NREGS_LIM);
    assign dbg_data = ({1'b0, dbg_addr} < NREGS_LIM) ? regs[dbg_addr] : 16'h0000;

    assign err = err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // in_ready is masked during the err pulse so the next accept lands the cycle after it.
    always_comb begin
        next_state = state;
        accept     = 1'b0;
        load_alu   = 1'b0;
        load_ldi   = 1'b0;
        capture    = 1'b0;
        div_dec    = 1'b0;
        set_err    = 1'b0;
        wr_en      = 1'b0;
        in_ready   = 1'b0;
        done       = 1'b0;
        case (state)
            S_IDLE: begin
                in_ready = !err_q;
                if (in_valid && !err_q) begin
                    accept     = 1'b1;
                    next_state = S_DECODE;
                end
            end
            S_DECODE: begin
                if (dec_is_alu) begin
                    load_alu   = 1'b1;
                    next_state = S_EXEC;
                end else if (dec_is_ldi) begin
                    load_ldi   = 1'b1;
                    next_state = S_WB;
                end else begin
                    set_err    = 1'b1;
                    next_state = S_IDLE;
                end
            end
            S_EXEC: begin
                if (div_cnt == '0) begin
                    capture    = 1'b1;
                    next_state = S_WB;
                end else begin
                    div_dec = 1'b1;
                end
            end
            S_WB: begin
                done       = 1'b1;
                wr_en      = 1'b1;
                next_state = S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
    end

    // ALU ports only change on an ALU-op decode, so they hold through EXEC and idle time.
    always_ff @(posedge clk) begin
        if (rst) begin
            instr_q  <= '0;
            result_q <= '0;
            div_cnt  <= '0;
            err_q    <= 1'b0;
            op_code  <= '0;
            rs1_in   <= '0;
            rs2_in   <= '0;
            cin      <= 1'b0;
            bin      <= 1'b0;
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            err_q <= set_err;
            if (accept) begin
                instr_q <= in_instr;
            end
            if (load_alu) begin
                op_code <= dec_op;
                rs1_in  <= read_a;
                rs2_in  <= read_b;
                cin     <= instr_q[2];
                bin     <= instr_q[1];
                div_cnt <= (dec_op == OP_DIV) ? DIV_LOAD : '0;
            end
            if (load_ldi) begin
                result_q <= {7'b0, dec_imm};
            end
            if (div_dec) begin
                div_cnt <= div_cnt - 1'b1;
            end
            if (capture) begin
                result_q <= alu_result;
            end
            if (wr_en && dst_ok) begin
                regs[dec_rd] <= result_q;
            end
        end
    end

`ifdef ALU_ISSUE_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_retired <= '0;
            perf_illegal <= '0;
        end else begin
            if (done) begin
                perf_retired <= perf_retired + 16'd1;
            end
            if (err_q) begin
                perf_illegal <= perf_illegal + 16'd1;
            end
        end
    end
`endif

endmodule
